// File: rtl/biriscv_exec_mc_pkg.sv
// Shared definitions for the multi-cycle execute unit: custom instruction
// mask/match pairs, op-type encodings and FSM state encodings.
// Custom ops live in the custom-0 major opcode (0001011), split by funct3.
package biriscv_exec_mc_pkg;

  localparam logic [31:0] INST_SAD_MASK     = 32'h0000_707f;
  localparam logic [31:0] INST_SAD_MATCH    = 32'h0000_000b;
  localparam logic [31:0] INST_CLMUL_MASK   = 32'h0000_707f;
  localparam logic [31:0] INST_CLMUL_MATCH  = 32'h0000_100b;
  localparam logic [31:0] INST_CLMULH_MASK  = 32'h0000_707f;
  localparam logic [31:0] INST_CLMULH_MATCH = 32'h0000_200b;

  typedef enum logic [1:0] {
    MC_OP_SAD    = 2'd0,
    MC_OP_CLMUL  = 2'd1,
    MC_OP_CLMULH = 2'd2
  } mc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/biriscv_mc_step.sv
// Single-iteration combinational datapath for the multi-cycle unit.
// Ports: op_i (op type), acc_i (64-bit accumulator), a_i/b_i (operands),
//        cnt_i (iteration index), acc_o (accumulator after this iteration).
module biriscv_mc_step
  import biriscv_exec_mc_pkg::*;
#(
  parameter int unsigned SAD_LANES     = 2,
  parameter int unsigned CLMUL_BITS    = 4,
  parameter int unsigned SUPPORT_CLMUL = 1,
  parameter int unsigned CNT_W         = 4
) (
  input  mc_op_e            op_i,
  input  logic [63:0]       acc_i,
  input  logic [31:0]       a_i,
  input  logic [31:0]       b_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic [63:0]       acc_o
);

  logic [31:0] sad_sum;
  logic [63:0] cl_acc;

  // SAD: add |a-b| for this iteration's byte lanes, lowest lane first
  always_comb begin : sad_step
    logic [1:0] lane;
    logic [7:0] ab;
    logic [7:0] bb;
    logic [7:0] ad;
    sad_sum = acc_i[31:0];
    lane    = '0;
    ab      = '0;
    bb      = '0;
    ad      = '0;
    for (int unsigned l = 0; l < SAD_LANES; l++) begin
      lane    = 2'(32'(cnt_i) * SAD_LANES + l);
      ab      = a_i[8*lane +: 8];
      bb      = b_i[8*lane +: 8];
      ad      = (ab >= bb) ? (ab - bb) : (bb - ab);
      sad_sum = sad_sum + 32'(ad);
    end
  end

  // CLMUL: xor in a shifted copy of a for every set rs2 bit in this chunk
  always_comb begin : clmul_step
    logic [4:0] j;
    cl_acc = acc_i;
    j      = '0;
    for (int unsigned k = 0; k < CLMUL_BITS; k++) begin
      j = 5'(32'(cnt_i) * CLMUL_BITS + k);
      if (b_i[j]) begin
        cl_acc = cl_acc ^ ({32'b0, a_i} << j);
      end
    end
  end

  // Result select by op type
  always_comb begin
    acc_o = acc_i;
    case (op_i)
      MC_OP_SAD:    acc_o = {acc_i[63:32], sad_sum};
      MC_OP_CLMUL,
      MC_OP_CLMULH: if (SUPPORT_CLMUL != 0) acc_o = cl_acc;
      default:      acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/biriscv_exec_mc.sv
// Multi-cycle execute unit for the iterative custom ops (SAD, CLMUL, CLMULH).
// Ports: clk_i/rst_ni; opcode_* issue slot (valid, instruction, rd, rs1..rs3);
//        hold_i (freezes DONE, blocks accept); kill_i (abort);
//        stall_o (busy); writeback_valid_o/idx_o/value_o (result strobe).
module biriscv_exec_mc
  import biriscv_exec_mc_pkg::*;
#(
  parameter int unsigned SAD_LANES     = 2,
  parameter int unsigned CLMUL_BITS    = 4,
  parameter int unsigned SUPPORT_CLMUL = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  input  logic [31:0] opcode_rc_operand_i,
  input  logic        hold_i,
  input  logic        kill_i,
  output logic        stall_o,
  output logic        writeback_valid_o,
  output logic [4:0]  writeback_idx_o,
  output logic [31:0] writeback_value_o
);

  localparam int unsigned SAD_ITERS   = 4 / SAD_LANES;
  localparam int unsigned CLMUL_ITERS = 32 / CLMUL_BITS;
  localparam int unsigned MAX_ITERS   = ((SUPPORT_CLMUL != 0) && (CLMUL_ITERS > SAD_ITERS))
                                        ? CLMUL_ITERS : SAD_ITERS;
  localparam int unsigned CNT_W       = (MAX_ITERS > 1) ? $clog2(MAX_ITERS) : 1;

  mc_state_e         state_q, state_d;
  mc_op_e            op_q, op_d, dec_op;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [4:0]        rd_q, rd_d, idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_last;
  logic [63:0]       acc_q, acc_d, step_acc;
  logic [31:0]       res_q, res_d;
  logic              is_sad, is_clmul, is_clmulh, ours;

  // Decode: only our custom ops are accepted; everything else is invisible
  always_comb begin
    is_sad    = (opcode_opcode_i & INST_SAD_MASK) == INST_SAD_MATCH;
    is_clmul  = (SUPPORT_CLMUL != 0) &&
                ((opcode_opcode_i & INST_CLMUL_MASK) == INST_CLMUL_MATCH);
    is_clmulh = (SUPPORT_CLMUL != 0) &&
                ((opcode_opcode_i & INST_CLMULH_MASK) == INST_CLMULH_MATCH);
    ours      = is_sad | is_clmul | is_clmulh;
    dec_op    = MC_OP_SAD;
    if (is_clmul)  dec_op = MC_OP_CLMUL;
    if (is_clmulh) dec_op = MC_OP_CLMULH;
  end

  biriscv_mc_step #(
    .SAD_LANES     (SAD_LANES),
    .CLMUL_BITS    (CLMUL_BITS),
    .SUPPORT_CLMUL (SUPPORT_CLMUL),
    .CNT_W         (CNT_W)
  ) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .cnt_i (cnt_q),
    .acc_o (step_acc)
  );

  assign cnt_last = (op_q == MC_OP_SAD) ? CNT_W'(SAD_ITERS - 1) : CNT_W'(CLMUL_ITERS - 1);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (opcode_valid_i && ours && !hold_i && !kill_i) begin
          state_d = ST_RUN;
          op_d    = dec_op;
          a_d     = opcode_ra_operand_i;
          b_d     = opcode_rb_operand_i;
          rd_d    = opcode_rd_idx_i;
          cnt_d   = '0;
          acc_d   = (dec_op == MC_OP_SAD) ? {32'b0, opcode_rc_operand_i} : 64'b0;
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == cnt_last) begin
          state_d = ST_DONE;
          res_d   = (op_q == MC_OP_CLMULH) ? step_acc[63:32] : step_acc[31:0];
          idx_d   = rd_q;
        end
      end
      ST_DONE: begin
        if (!hold_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Kill aborts from any state and must not disturb the visible result
    if (kill_i) begin
      state_d = ST_IDLE;
      res_d   = res_q;
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= MC_OP_SAD;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
    end
  end

  // Strobe is the registered DONE state qualified by this cycle's hold/kill
  assign stall_o           = (state_q != ST_IDLE);
  assign writeback_valid_o = (state_q == ST_DONE) & ~hold_i & ~kill_i;
  assign writeback_idx_o   = idx_q;
  assign writeback_value_o = res_q;

endmodule

// File: doc/biriscv_exec_mc.md
Name: biriscv_exec_mc

Overview:
Parametrised multi-cycle execute unit placed beside the single-cycle execute pipe. It runs the iterative custom ops:
- SAD: sum of absolute byte differences, accumulated into rs3.
- CLMUL / CLMULH: carry-less multiply, low and high word.

Each op is processed over several cycles, with lanes or bits handled per cycle set by parameters. The unit stalls issue while busy and presents a one-cycle writeback pulse with the destination index.

Parameters:
SAD_LANES, 2, byte lanes summed per cycle; legal 1, 2, 4.
CLMUL_BITS, 4, rs2 bits consumed per cycle; legal 1, 2, 4, 8, 16, 32.
SUPPORT_CLMUL, 1, 0 removes the CLMUL datapath; CLMUL/CLMULH are then not accepted.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
opcode_valid_i  in  1  issue slot valid
opcode_opcode_i  in  32  instruction word
opcode_rd_idx_i  in  5  destination register
opcode_ra_operand_i  in  32  rs1 value
opcode_rb_operand_i  in  32  rs2 value
opcode_rc_operand_i  in  32  rs3 value (SAD accumulator)
hold_i  in  1  pipeline hold; freezes the DONE state and blocks acceptance
kill_i  in  1  flush; aborts any in-flight op
stall_o  out  1  high while an op is in RUN or DONE
writeback_valid_o  out  1  one-cycle result strobe
writeback_idx_o  out  5  destination register of the result
writeback_value_o  out  32  result

Behaviour:
- Decode:
  - An op is "ours" when opcode_opcode_i matches the INST_SAD, INST_CLMUL or INST_CLMULH mask/match pairs.
  - Any other opcode is ignored: no acceptance, no stall.
- Accept condition: opcode_valid_i & ours & state==IDLE & ~hold_i & ~kill_i.
- On accept, the unit latches:
  - operands a, b, c;
  - rd index;
  - op type;
  - iteration counter = 0.
- FSM states:
  - IDLE -> RUN on accept.
  - RUN -> DONE after the last iteration.
  - DONE -> IDLE on the cycle ~hold_i.
  - Any state -> IDLE on kill_i, with no writeback.
- Iteration counts:
  - SAD: 4/SAD_LANES cycles.
  - CLMUL/CLMULH: 32/CLMUL_BITS cycles.
  - Counter width: clog2 of the maximum count, minimum 1 bit.
- SAD datapath:
  - acc initialised to rs3.
  - Each RUN cycle adds |a[8i+7:8i] - b[8i+7:8i]| for the next SAD_LANES lanes, lowest lane first.
  - Bytes are unsigned; the absolute difference is 8 bits.
  - Sum wraps modulo 2^32.
- CLMUL datapath:
  - 64-bit acc initialised to 0.
  - For bit j of rs2 in the current chunk: if b[j], acc ^= {32'b0, a} << j.
  - CLMUL returns acc[31:0]; CLMULH returns acc[63:32].
- Latency:
  - Accept on cycle 0; RUN occupies cycles 1..N.
  - writeback_valid_o is high in the first DONE cycle with ~hold_i, i.e. cycle N+1 with no hold.
  - stall_o is asserted from cycle 1 until the cycle after the writeback.
- hold_i in DONE: result, index and state are frozen; writeback_valid_o is held 0 until hold_i drops.
- kill_i and writeback on the same cycle: kill wins; writeback_valid_o = 0.
- Back-to-back: a new op may be accepted in the cycle after the writeback (stall_o low, IDLE). There is no acceptance on the writeback cycle itself.
- Reset (any time, including mid-RUN):
  - State IDLE; accumulators and counter 0.
  - stall_o = 0, writeback_valid_o = 0, writeback_idx_o = 0, writeback_value_o = 0.
- Outputs are registered.
- writeback_value_o and writeback_idx_o keep their last value after the strobe.

Decomposition:
- Shared package / biriscv_defs.v holds:
  - INST_SAD, INST_CLMUL, INST_CLMULH mask and match constants;
  - MC_OP_SAD / MC_OP_CLMUL / MC_OP_CLMULH op-type encodings;
  - FSM state encodings.
- One sub-module, biriscv_mc_step: purely combinational single-iteration datapath.
  - Inputs: op, acc, a, b, counter.
  - Output: next acc.
  - Parametrised by SAD_LANES and CLMUL_BITS.
- The top level holds the FSM, operand registers and output registers.

Test Plan:
- SAD, default parameters: a=0x0A141E28, b=0x0514283C, rc=100, rd=7 -> stall for 2 RUN cycles; writeback_valid_o at cycle 3, value 135 (0x87), idx 7.
- CLMUL/CLMULH, CLMUL_BITS=4:
  - CLMUL a=0x3, b=0x3 -> 0x00000005 at cycle 9.
  - CLMULH a=0x80000000, b=0x2 -> 0x00000001.
  - CLMUL of the same operands -> 0x00000000.
- SAD wrap: a=0xFF00FF00, b=0x00FF00FF, rc=0xFFFFFF00 -> 0x000002FC (1020 added, mod 2^32).
- hold_i raised in DONE for 3 cycles -> no strobe during hold, value stable; strobe on the first cycle after hold falls; next op accepted the following cycle.
- kill_i in the 2nd RUN cycle of a CLMUL -> state IDLE next cycle, stall_o 0, no writeback ever for that op.
- rst_ni pulsed low mid-RUN (async, off-edge) -> all outputs 0 immediately; after release a fresh SAD completes with correct value; a non-custom opcode (ADD) is never accepted or stalled.
